// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the memory-access stage: size encodings, FSM states and
// byte-enable constants.
package mem_access_pkg;

    typedef enum logic [1:0] {
        SzNone = 2'b00,
        SzByte = 2'b01,
        SzHalf = 2'b10,
        SzWord = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StDone
    } state_e;

    localparam logic [3:0] BeNone   = 4'b0000;
    localparam logic [3:0] BeByte   = 4'b0001;
    localparam logic [3:0] BeHalfLo = 4'b0011;
    localparam logic [3:0] BeHalfHi = 4'b1100;
    localparam logic [3:0] BeWord   = 4'b1111;

    function automatic logic [3:0] byte_en(input size_e size, input logic [1:0] addr);
        case (size)
            SzByte:  byte_en = BeByte << addr;
            SzHalf:  byte_en = addr[1] ? BeHalfHi : BeHalfLo;
            SzWord:  byte_en = BeWord;
            default: byte_en = BeNone;
        endcase
    endfunction

    function automatic logic is_misaligned(input size_e size, input logic [1:0] addr);
        case (size)
            SzHalf:  is_misaligned = addr[0];
            SzWord:  is_misaligned = |addr;
            default: is_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ma_load_align.sv
// Load lane select and sign/zero extension of a memory word into a 32-bit result.
module ma_load_align
    import mem_access_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr,
    input  size_e       i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        case (i_addr)
            2'd0: w_byte = i_word[7:0];
            2'd1: w_byte = i_word[15:8];
            2'd2: w_byte = i_word[23:16];
            2'd3: w_byte = i_word[31:24];
            default: w_byte = 8'h00;
        endcase
        w_half = i_addr[1] ? i_word[31:16] : i_word[15:0];

        case (i_size)
            SzByte:  o_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
            SzHalf:  o_data = {{16{~i_unsigned & w_half[15]}}, w_half};
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-access stage engine: IDLE -> ACCESS -> DONE handshake with a variable-latency data
// memory. Define MA_MISALIGN_TRAP_EN to trap misaligned half/word accesses (adds o_misaligned).
module mem_access_unit
    import mem_access_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_alu_result,
    input  logic [31:0] i_store_data,
    input  logic [1:0]  i_mem_read,
    input  logic [1:0]  i_mem_write,
    input  logic        i_load_unsigned,
    output logic [31:0] o_dm_addr,
    output logic [31:0] o_dm_write_data,
    output logic [3:0]  o_dm_byte_en,
    output logic        o_dm_read,
    output logic        o_dm_write,
    input  logic        i_dm_ready,
    input  logic [31:0] i_dm_read_data,
    output logic [31:0] o_load_data,
    output logic        o_load_valid,
    output logic        o_busy
`ifdef MA_MISALIGN_TRAP_EN
    ,
    output logic        o_misaligned
`endif
);

    state_e      r_state;
    logic [1:0]  r_addr_lo;
    size_e       r_size;
    logic        r_unsigned;
    logic [31:0] r_dm_addr;
    logic [31:0] r_dm_wdata;
    logic [3:0]  r_dm_be;
    logic        r_dm_read;
    logic        r_dm_write;
    logic [31:0] r_load_data;
    logic        r_load_valid;
`ifdef MA_MISALIGN_TRAP_EN
    logic        r_misaligned;
`endif

    logic        w_req;
    logic        w_is_write;
    size_e       w_size;
    logic [31:0] w_wdata;
    logic [31:0] w_aligned;

    assign w_req      = (i_mem_read != 2'b00) || (i_mem_write != 2'b00);
    assign w_is_write = (i_mem_write != 2'b00);
    // A simultaneous read request is dropped in favour of the write.
    assign w_size     = w_is_write ? size_e'(i_mem_write) : size_e'(i_mem_read);

    always_comb begin
        case (w_size)
            SzByte:  w_wdata = {4{i_store_data[7:0]}};
            SzHalf:  w_wdata = {2{i_store_data[15:0]}};
            default: w_wdata = i_store_data;
        endcase
    end

    ma_load_align u_load_align (
        .i_word     (i_dm_read_data),
        .i_addr     (r_addr_lo),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_data     (w_aligned)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= StIdle;
            r_addr_lo    <= 2'b00;
            r_size       <= SzNone;
            r_unsigned   <= 1'b0;
            r_dm_addr    <= 32'h0;
            r_dm_wdata   <= 32'h0;
            r_dm_be      <= BeNone;
            r_dm_read    <= 1'b0;
            r_dm_write   <= 1'b0;
            r_load_data  <= 32'h0;
            r_load_valid <= 1'b0;
`ifdef MA_MISALIGN_TRAP_EN
            r_misaligned <= 1'b0;
`endif
        end else begin
            r_load_valid <= 1'b0;
`ifdef MA_MISALIGN_TRAP_EN
            r_misaligned <= 1'b0;
`endif
            case (r_state)
                StIdle: begin
                    if (w_req) begin
                        r_addr_lo  <= i_alu_result[1:0];
                        r_size     <= w_size;
                        r_unsigned <= i_load_unsigned;
                        r_dm_addr  <= {i_alu_result[31:2], 2'b00};
                        r_dm_wdata <= w_wdata;
                        r_dm_be    <= byte_en(w_size, i_alu_result[1:0]);
`ifdef MA_MISALIGN_TRAP_EN
                        if (is_misaligned(w_size, i_alu_result[1:0])) begin
                            r_misaligned <= 1'b1;
                            r_load_data  <= 32'h0;
                            r_state      <= StDone;
                        end else
`endif
                        begin
                            r_dm_read  <= ~w_is_write;
                            r_dm_write <= w_is_write;
                            r_state    <= StAccess;
                        end
                    end
                end
                StAccess: begin
                    if (i_dm_ready) begin
                        if (r_dm_read) begin
                            r_load_data  <= w_aligned;
                            r_load_valid <= 1'b1;
                        end
                        r_dm_read  <= 1'b0;
                        r_dm_write <= 1'b0;
                        r_state    <= StDone;
                    end
                end
                // EX/MA still holds the completed op here; never re-trigger on it.
                StDone:  r_state <= StIdle;
                default: r_state <= StIdle;
            endcase
        end
    end

    // Reset gating keeps BUSY low while reset is held even if EX/MA still shows an op.
    assign o_busy = (r_state == StAccess) || ((r_state == StIdle) && w_req && i_rst_n);

    assign o_dm_addr       = r_dm_addr;
    assign o_dm_write_data = r_dm_wdata;
    assign o_dm_byte_en    = r_dm_be;
    assign o_dm_read       = r_dm_read;
    assign o_dm_write      = r_dm_write;
    assign o_load_data     = r_load_data;
    assign o_load_valid    = r_load_valid;
`ifdef MA_MISALIGN_TRAP_EN
    assign o_misaligned    = r_misaligned;
`endif

endmodule
